// File: rtl/cnn_job_scheduler.sv
// cnn_job_scheduler
//   Shares one CNN core between NUM_REQ requesters. For each job it grants one
//   requester (round-robin), streams that requester's IMG_SIZE-word image into the
//   core image buffer, runs the core and returns the prediction tagged with the
//   requester index.
//   Optional run watchdog: define CNN_TIMEOUT_EN to abort a RUN that lasts
//   TIMEOUT_CYCLES cycles without core_done (result flagged by res_err).
module cnn_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int IMG_SIZE       = 64,
  parameter int DATA_W         = 32,
  parameter int OUT_W          = 32,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          grant,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        img_wr_en,
  output logic [$clog2(IMG_SIZE)-1:0] img_wr_addr,
  output logic [DATA_W-1:0]           img_wr_data,
  output logic                        core_enable,
  input  logic                        core_done,
  input  logic [OUT_W-1:0]            core_value,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [OUT_W-1:0]            res_data,
  output logic [ID_W-1:0]             res_id,
  output logic                        res_err,
  output logic                        busy
);

  localparam int AW = $clog2(IMG_SIZE);

  // Reject configurations the arbiter or word counter cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << ID_W) < NUM_REQ || IMG_SIZE < 2 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cnn_job_scheduler: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_RESP
  } state_t;

  state_t               state_q,       state_d;
  logic [ID_W-1:0]      ptr_q,         ptr_d;
  logic [NUM_REQ-1:0]   grant_q,       grant_d;
  logic [ID_W-1:0]      res_id_q,      res_id_d;
  logic                 in_ready_q,    in_ready_d;
  logic [AW-1:0]        cnt_q,         cnt_d;
  logic                 img_wr_en_q,   img_wr_en_d;
  logic [AW-1:0]        img_wr_addr_q, img_wr_addr_d;
  logic [DATA_W-1:0]    img_wr_data_q, img_wr_data_d;
  logic                 core_enable_q, core_enable_d;
  logic                 res_valid_q,   res_valid_d;
  logic [OUT_W-1:0]     res_data_q,    res_data_d;
  logic                 busy_q,        busy_d;

`ifdef CNN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]        timer_q,       timer_d;
  logic                 res_err_q,     res_err_d;
`endif

  // ------------------------------------------------------------------
  // Round-robin winner: lowest requesting index at or above the pointer,
  // otherwise (wrap-around) the lowest requesting index overall.
  // ------------------------------------------------------------------
  logic [NUM_REQ-1:0] upper_req;
  logic [ID_W-1:0]    upper_win;
  logic               upper_hit;
  logic [ID_W-1:0]    any_win;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    ptr_after_win;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
    assign upper_req[gi] = req[gi] && (ID_W'(gi) >= ptr_q);
  end

  // Priority scan: descending loop so the lowest matching index is kept last.
  always_comb begin
    upper_win = '0;
    upper_hit = 1'b0;
    any_win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        upper_win = ID_W'(i);
        upper_hit = 1'b1;
      end
      if (req[i]) begin
        any_win = ID_W'(i);
      end
    end
    winner        = upper_hit ? upper_win : any_win;
    ptr_after_win = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  end

  // ------------------------------------------------------------------
  // Job sequencing: next-state and next-output computation.
  // ------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    res_id_d      = res_id_q;
    in_ready_d    = in_ready_q;
    cnt_d         = cnt_q;
    img_wr_en_d   = 1'b0;
    img_wr_addr_d = img_wr_addr_q;
    img_wr_data_d = img_wr_data_q;
    core_enable_d = core_enable_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
`ifdef CNN_TIMEOUT_EN
    timer_d       = timer_q;
    res_err_d     = res_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d    = NUM_REQ'(1) << winner;
          res_id_d   = winner;
          ptr_d      = ptr_after_win;
          cnt_d      = '0;
          in_ready_d = 1'b1;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // in_ready is high for the whole of LOAD, so in_valid alone accepts a word.
        if (in_valid) begin
          img_wr_en_d   = 1'b1;
          img_wr_addr_d = cnt_q;
          img_wr_data_d = in_data;
          if (cnt_q == AW'(IMG_SIZE - 1)) begin
            cnt_d         = '0;
            in_ready_d    = 1'b0;
            core_enable_d = 1'b1;
            state_d       = ST_START;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      ST_START: begin
        // The final image write lands during this cycle; the core starts next.
`ifdef CNN_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (core_done) begin
          res_data_d    = core_value;
          res_valid_d   = 1'b1;
          core_enable_d = 1'b0;
          state_d       = ST_RESP;
`ifdef CNN_TIMEOUT_EN
          res_err_d     = 1'b0;
`endif
        end
`ifdef CNN_TIMEOUT_EN
        // A completion in the expiry cycle takes precedence (branch above).
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_data_d    = '0;
          res_err_d     = 1'b1;
          res_valid_d   = 1'b1;
          core_enable_d = 1'b0;
          state_d       = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end

      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          grant_d     = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ------------------------------------------------------------------
  // State and registered outputs; reset aborts any job in flight.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      res_id_q      <= '0;
      in_ready_q    <= 1'b0;
      cnt_q         <= '0;
      img_wr_en_q   <= 1'b0;
      img_wr_addr_q <= '0;
      img_wr_data_q <= '0;
      core_enable_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      busy_q        <= 1'b0;
`ifdef CNN_TIMEOUT_EN
      timer_q       <= '0;
      res_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      res_id_q      <= res_id_d;
      in_ready_q    <= in_ready_d;
      cnt_q         <= cnt_d;
      img_wr_en_q   <= img_wr_en_d;
      img_wr_addr_q <= img_wr_addr_d;
      img_wr_data_q <= img_wr_data_d;
      core_enable_q <= core_enable_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      busy_q        <= busy_d;
`ifdef CNN_TIMEOUT_EN
      timer_q       <= timer_d;
      res_err_q     <= res_err_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign in_ready    = in_ready_q;
  assign img_wr_en   = img_wr_en_q;
  assign img_wr_addr = img_wr_addr_q;
  assign img_wr_data = img_wr_data_q;
  assign core_enable = core_enable_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_id      = res_id_q;
  assign busy        = busy_q;

`ifdef CNN_TIMEOUT_EN
  assign res_err = res_err_q;
`else
  // Without the watchdog every result comes from the core.
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_job_scheduler.sv
// tb_cnn_job_scheduler: directed self-checking bench for cnn_job_scheduler.
// Define CNN_TIMEOUT_EN for both files to include the watchdog scenarios.
module tb_cnn_job_scheduler;

  localparam int NREQ = 4;
  localparam int IMG  = 64;
  localparam int DW   = 32;
  localparam int OW   = 32;
  localparam int IDW  = 2;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            img_wr_en;
  logic [5:0]      img_wr_addr;
  logic [DW-1:0]   img_wr_data;
  logic            core_enable;
  logic            core_done;
  logic [OW-1:0]   core_value;
  logic            res_valid;
  logic            res_ready;
  logic [OW-1:0]   res_data;
  logic [IDW-1:0]  res_id;
  logic            res_err;
  logic            busy;

  int total = 0;
  int bad   = 0;

  logic [5:0]    wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];

  always #5 clk = ~clk;

  cnn_job_scheduler #(
    .NUM_REQ(NREQ), .IMG_SIZE(IMG), .DATA_W(DW), .OUT_W(OW), .ID_W(IDW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
    .core_enable(core_enable), .core_done(core_done), .core_value(core_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err), .busy(busy)
  );

  // Record every image-buffer write the scheduler issues.
  always @(negedge clk) begin
    if (rst && img_wr_en) begin
      wr_addr_log.push_back(img_wr_addr);
      wr_data_log.push_back(img_wr_data);
    end
  end

  // Absolute safety net.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; in_valid = 1'b0; in_data = '0;
    core_done = 1'b0; core_value = '0; res_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Present n words (base + step*k); optional random in_valid gaps.
  task automatic feed_image(input int n, input bit gaps, input logic [DW-1:0] base,
                            input int step);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = base + DW'(step * k);
      if (in_valid && in_ready) k++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (k < n) begin
      bad++;
      $display("FAIL feed_words: accepted=%0d want %0d", k, n);
    end
  endtask

  // Core model: after core_enable, wait 'delay' cycles then hold done until res_valid.
  task automatic core_respond(input int delay, input logic [OW-1:0] val);
    int g = 0;
    while (!core_enable && g < 500) begin tick(); g++; end
    total++;
    if (!core_enable) begin
      bad++;
      $display("FAIL core_enable_wait: got 0 want 1");
    end
    repeat (delay) tick();
    core_done = 1'b1;
    core_value = val;
    g = 0;
    while (!res_valid && g < 500) begin tick(); g++; end
    core_done = 1'b0;
    core_value = '0;
    total++;
    if (!res_valid) begin
      bad++;
      $display("FAIL res_valid_wait: got 0 want 1");
    end
    $display("txn result id=%0d data=%0h err=%0b", res_id, res_data, res_err);
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; in_valid = 1'b0; in_data = '0;
    core_done = 1'b0; core_value = '0; res_ready = 1'b0;
    repeat (2) tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant: got %b want 0000", grant); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (img_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", img_wr_en); end
    total++; if (img_wr_addr !== 6'd0) begin bad++; $display("FAIL rst_wr_addr: got %0d want 0", img_wr_addr); end
    total++; if (img_wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr_data: got %0h want 0", img_wr_data); end
    total++; if (core_enable !== 1'b0) begin bad++; $display("FAIL rst_core_enable: got %b want 0", core_enable); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    total++; if (res_data !== 32'd0) begin bad++; $display("FAIL rst_res_data: got %0h want 0", res_data); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL rst_res_id: got %0d want 0", res_id); end
    total++; if (res_err !== 1'b0) begin bad++; $display("FAIL rst_res_err: got %b want 0", res_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    req = '0;
    rst = 1'b1;
    tick();
    total++; if (grant !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL post_rst_idle: grant=%b busy=%b want 0000/0", grant, busy);
    end
    $display("txn reset done");
  endtask

  task automatic test_single();
    int errs = 0;
    wr_addr_log.delete(); wr_data_log.delete();
    req = 4'b0010; in_valid = 1'b1; in_data = 32'd1;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", grant); end
    total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_load: in_ready=%b busy=%b want 1/1", in_ready, busy);
    end
    req = 4'b0000;  // dropping req must not abort the job
    feed_image(IMG, 1'b0, 32'd1, 0);
    total++; if (in_ready !== 1'b0 || core_enable !== 1'b1) begin
      bad++; $display("FAIL single_start: in_ready=%b core_enable=%b want 0/1", in_ready, core_enable);
    end
    total++; if (img_wr_en !== 1'b1 || img_wr_addr !== 6'd63) begin
      bad++; $display("FAIL single_last_write: en=%b addr=%0d want 1/63", img_wr_en, img_wr_addr);
    end
    core_respond(2, 32'd64);
    total++; if (res_data !== 32'd64 || res_id !== 2'd1 || res_err !== 1'b0) begin
      bad++; $display("FAIL single_result: data=%0d id=%0d err=%b want 64/1/0", res_data, res_id, res_err);
    end
    total++; if (core_enable !== 1'b0 || grant !== 4'b0010) begin
      bad++; $display("FAIL single_resp_state: core_enable=%b grant=%b want 0/0010", core_enable, grant);
    end
    for (int i = 0; i < wr_addr_log.size(); i++)
      if (wr_addr_log[i] !== 6'(i) || wr_data_log[i] !== 32'd1) errs++;
    total++; if (wr_addr_log.size() != IMG || errs != 0) begin
      bad++; $display("FAIL single_writes: count=%0d bad_entries=%0d want 64/0", wr_addr_log.size(), errs);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL single_release: res_valid=%b grant=%b busy=%b want 0/0000/0", res_valid, grant, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      total++; if (grant !== (4'b0001 << exp_ids[j]) || res_id !== 2'(exp_ids[j])) begin
        bad++; $display("FAIL rr_grant%0d: grant=%b id=%0d want id %0d", j, grant, res_id, exp_ids[j]);
      end
      feed_image(IMG, 1'b0, DW'(j * 100), 1);
      core_respond(1, 32'h100 + DW'(j));
      total++; if (res_id !== 2'(exp_ids[j]) || res_data !== 32'h100 + DW'(j)) begin
        bad++; $display("FAIL rr_result%0d: id=%0d data=%0h want %0d/%0h", j, res_id, res_data, exp_ids[j], 32'h100 + j);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      // Exactly one idle cycle between release and the next grant.
      total++; if (grant !== 4'b0000 || busy !== 1'b0) begin
        bad++; $display("FAIL rr_gap%0d: grant=%b busy=%b want 0000/0", j, grant, busy);
      end
    end
    req = 4'b1001;  // pointer is now 1, so requester 3 wins
    tick();
    total++; if (grant !== 4'b1000 || res_id !== 2'd3) begin
      bad++; $display("FAIL rr_wrap: grant=%b id=%0d want 1000/3", grant, res_id);
    end
    req = 4'b0000;
    feed_image(IMG, 1'b0, 32'd0, 1);
    core_respond(1, 32'h55);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_stall();
    int errs = 0;
    wr_addr_log.delete(); wr_data_log.delete();
    req = 4'b0100;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL stall_grant: got %b want 0100", grant); end
    req = 4'b0000;
    feed_image(IMG, 1'b1, 32'hA5A5_0000, 3);
    core_respond(0, 32'hDEAD_BEEF);  // done already high on entry to RUN
    for (int i = 0; i < wr_addr_log.size(); i++)
      if (wr_addr_log[i] !== 6'(i) || wr_data_log[i] !== 32'hA5A5_0000 + DW'(3 * i)) errs++;
    total++; if (wr_addr_log.size() != IMG || errs != 0) begin
      bad++; $display("FAIL stall_writes: count=%0d bad_entries=%0d want 64/0", wr_addr_log.size(), errs);
    end
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (res_valid !== 1'b1 || res_data !== 32'hDEAD_BEEF || res_id !== 2'd2 || grant !== 4'b0100) begin
        bad++; $display("FAIL stall_hold%0d: valid=%b data=%0h id=%0d grant=%b want 1/deadbeef/2/0100",
                        c, res_valid, res_data, res_id, grant);
      end
    end
    req = 4'b0000;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: busy=%b valid=%b want 0/0", busy, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    int errs = 0;
    req = 4'b0001;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_grant: got %b want 0001", grant); end
    req = 4'b0000;
    feed_image(30, 1'b0, 32'h77, 1);
    in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++; if (grant !== 4'b0000 || in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_async: grant=%b in_ready=%b busy=%b want 0000/0/0", grant, in_ready, busy);
    end
    total++; if (img_wr_en !== 1'b0 || img_wr_addr !== 6'd0) begin
      bad++; $display("FAIL mid_async_wr: en=%b addr=%0d want 0/0", img_wr_en, img_wr_addr);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (res_valid !== 1'b0 || grant !== 4'b0000) begin
      bad++; $display("FAIL mid_no_result: valid=%b grant=%b want 0/0000", res_valid, grant);
    end
    wr_addr_log.delete(); wr_data_log.delete();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    feed_image(IMG, 1'b0, 32'd7, 1);
    core_respond(1, 32'd99);
    total++; if (res_id !== 2'd3 || res_data !== 32'd99) begin
      bad++; $display("FAIL mid_fresh_result: id=%0d data=%0d want 3/99", res_id, res_data);
    end
    for (int i = 0; i < wr_addr_log.size(); i++)
      if (wr_addr_log[i] !== 6'(i) || wr_data_log[i] !== 32'd7 + DW'(i)) errs++;
    total++; if (wr_addr_log.size() != IMG || errs != 0) begin
      bad++; $display("FAIL mid_fresh_writes: count=%0d bad_entries=%0d want 64/0", wr_addr_log.size(), errs);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

`ifdef CNN_TIMEOUT_EN
  task automatic test_timeout();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    feed_image(IMG, 1'b0, 32'd3, 0);  // returns in START
    repeat (16) tick();                // last RUN cycle
    total++; if (res_valid !== 1'b0 || core_enable !== 1'b1) begin
      bad++; $display("FAIL tmo_early: valid=%b core_enable=%b want 0/1", res_valid, core_enable);
    end
    tick();
    total++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 32'd0 || core_enable !== 1'b0) begin
      bad++; $display("FAIL tmo_expire: valid=%b err=%b data=%0h core_enable=%b want 1/1/0/0",
                      res_valid, res_err, res_data, core_enable);
    end
    $display("txn timeout id=%0d err=%b", res_id, res_err);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    feed_image(IMG, 1'b0, 32'd4, 0);
    repeat (16) tick();
    core_done = 1'b1;
    core_value = 32'd77;
    tick();
    core_done = 1'b0;
    core_value = '0;
    total++; if (res_valid !== 1'b1 || res_err !== 1'b0 || res_data !== 32'd77 || res_id !== 2'd1) begin
      bad++; $display("FAIL tmo_coincide: valid=%b err=%b data=%0d id=%0d want 1/0/77/1",
                      res_valid, res_err, res_data, res_id);
    end
    $display("txn coincide id=%0d data=%0d err=%b", res_id, res_data, res_err);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
`ifdef CNN_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
